// File: rtl/stream_pkg.sv
// Shared types and constants for the frame-to-UART streamer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: FSM state enum, default header bytes, baud divisor helper.
package stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_CSUM,
        ST_FINISH
    } state_t;

    localparam logic [7:0] HDR0_DEFAULT = 8'hA5;
    localparam logic [7:0] HDR1_DEFAULT = 8'h5A;

    // Cycles per UART bit, floor of clk_hz / baud.
    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first; start bit begins the cycle after acceptance.
// Latency: 1 cycle from accept to start bit; a byte occupies 10*BAUD_DIV cycles.
// Backpressure: ready_out high while idle and in the last stop-bit cycle, so bytes chain with no gap.
// Ports: clk_in, rst_in (async, active high), data_in[7:0]/valid_in/ready_out byte handshake,
//        txd_out serial line (idles high).
module uart_tx_byte #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       txd_out
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    logic          busy_q, busy_d;
    logic [8:0]    shift_q, shift_d;    // remaining bits: data then stop
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;        // 0 = start, 1..8 = data, 9 = stop
    logic          txd_q, txd_d;
    logic          bit_end;

    always_comb begin
        busy_d  = busy_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        txd_d   = txd_q;

        bit_end   = busy_q && (baud_q == BAUD_LAST);
        ready_out = !busy_q || (bit_end && (bit_q == 4'd9));

        if (busy_q) begin
            if (bit_end) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                    txd_d  = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    txd_d   = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end

        // A new byte overrides the stop-bit wind-down so it follows seamlessly.
        if (valid_in && ready_out) begin
            busy_d  = 1'b1;
            shift_d = {1'b1, data_in};
            txd_d   = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= 1'b0;
            shift_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    assign txd_out = txd_q;

endmodule

// File: rtl/frame_uart_streamer.sv
// Streams one stored frame as a UART packet: HDR0, HDR1, NUM_PIXELS payload bytes, 8-bit sum checksum.
// Latency: start_in at t -> busy_out at t+1 -> first start bit at t+2; done_out the cycle after the last stop bit.
// Backpressure: start_in is ignored while busy; BRAM reads are prefetched one byte ahead of the serializer.
// Ports: clk_in, rst_in (async assert, sync release), start_in, rd_addr_out/rd_data_in BRAM read port,
//        busy_out, done_out, uart_txd_out.
module frame_uart_streamer
    import stream_pkg::*;
#(
    parameter int         CLK_HZ      = 100_000_000,
    parameter int         BAUD        = 115200,
    parameter int         ADDR_W      = 16,
    parameter int         NUM_PIXELS  = 57600,
    parameter int         RAM_LATENCY = 2,
    parameter logic [7:0] HDR0        = HDR0_DEFAULT,
    parameter logic [7:0] HDR1        = HDR1_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [7:0]        rd_data_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              uart_txd_out
);

    localparam int              BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
    localparam logic [ADDR_W:0] PIX_LAST = (ADDR_W + 1)'(NUM_PIXELS - 1);

    // Reset asserts immediately, releases two clock edges later.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]     pix_cnt_q, pix_cnt_d;      // payload bytes accepted so far
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          hold_q, hold_d;
    logic                hold_vld_q, hold_vld_d;
    logic [RAM_LATENCY:0] rd_pipe_q, rd_pipe_d;    // in-flight read tokens
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                issue;
    logic                tx_valid, tx_ready;
    logic [7:0]          tx_data;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        pix_cnt_d  = pix_cnt_q;
        csum_d     = csum_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d    = ST_HDR0;
                    busy_d     = 1'b1;
                    rd_addr_d  = '0;
                    pix_cnt_d  = '0;
                    csum_d     = '0;
                    hold_vld_d = 1'b0;
                    issue      = 1'b1;
                end
            end
            ST_HDR0: begin
                tx_valid = 1'b1;
                tx_data  = HDR0;
                if (tx_ready) state_d = ST_HDR1;
            end
            ST_HDR1: begin
                tx_valid = 1'b1;
                tx_data  = HDR1;
                if (tx_ready) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                tx_valid = hold_vld_q;
                tx_data  = hold_q;
                if (hold_vld_q && tx_ready) begin
                    csum_d     = csum_q + hold_q;
                    hold_vld_d = 1'b0;
                    pix_cnt_d  = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == PIX_LAST) begin
                        state_d = ST_CSUM;
                    end else begin
                        // Prefetch the next pixel while this one is on the wire.
                        rd_addr_d = rd_addr_q + 1'b1;
                        issue     = 1'b1;
                    end
                end
            end
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                // tx_ready here marks the final cycle of the checksum stop bit.
                if (tx_ready) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Token reaches the top stage when rd_data_in reflects the registered address.
        rd_pipe_d = {rd_pipe_q[RAM_LATENCY-1:0], issue};
        if (rd_pipe_q[RAM_LATENCY]) begin
            hold_d     = rd_data_in;
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            pix_cnt_q  <= '0;
            csum_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            rd_pipe_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            pix_cnt_q  <= pix_cnt_d;
            csum_q     <= csum_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            rd_pipe_q  <= rd_pipe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk_in    (clk_in),
        .rst_in    (rst_sync_q),
        .data_in   (tx_data),
        .valid_in  (tx_valid),
        .ready_out (tx_ready),
        .txd_out   (uart_txd_out)
    );

    assign rd_addr_out = rd_addr_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Directed bench: two streamer instances (4-pixel and 1-pixel frames) with 2-cycle BRAM models.
// Latency: each packet is decoded cycle by cycle from its first start bit.
// Backpressure: n/a.
module tb_frame_uart_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] rd_addr0, rd_addr1;
    logic [7:0]  r0_d1, r0_dat, r1_d1, r1_dat;
    logic        busy0, busy1, done0, done1, txd0, txd1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem0 [0:3];
    logic [7:0] exp0 [0:6];
    logic [7:0] exp1 [0:3];
    logic [7:0] rx_bytes [0:6];

    always #5 clk = ~clk;

    frame_uart_streamer #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(16), .NUM_PIXELS(4), .RAM_LATENCY(2)
    ) dut0 (
        .clk_in(clk), .rst_in(rst), .start_in(start0), .rd_addr_out(rd_addr0),
        .rd_data_in(r0_dat), .busy_out(busy0), .done_out(done0), .uart_txd_out(txd0)
    );

    frame_uart_streamer #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(16), .NUM_PIXELS(1), .RAM_LATENCY(2)
    ) dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start1), .rd_addr_out(rd_addr1),
        .rd_data_in(r1_dat), .busy_out(busy1), .done_out(done1), .uart_txd_out(txd1)
    );

    // Registered-output BRAM models, two cycles from address to data.
    always @(posedge clk) begin
        r0_d1  <= (rd_addr0 < 16'd4) ? mem0[rd_addr0[1:0]] : 8'h00;
        r0_dat <= r0_d1;
        r1_d1  <= (rd_addr1 == 16'd0) ? 8'hFF : 8'h00;
        r1_dat <= r1_d1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic txd_of(input int sel);
        return (sel == 0) ? txd0 : txd1;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    task automatic pulse_start(input int sel, input string tag);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        check_eq({tag, "_busy_rise"}, 32'(busy_of(sel)), 32'd1);
    endtask

    // Decode a whole packet from the first start bit; optional extra start pulse at cycle restart_k.
    task automatic recv_packet(input int sel, input int nbytes, input int restart_k, input string tag);
        int   w = 0;
        int   glitch = 0, ferr = 0, busy_drop = 0, done_early = 0;
        int   nonmono = 0, oob = 0;
        logic [15:0] prev_addr = 16'd0;
        logic [15:0] max_addr  = 16'd0;
        logic [3:0]  seen = 4'd0;
        logic bitv = 1'b1;
        while (txd_of(sel) !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, "_start_latency_le3"}, 32'(w <= 3), 32'd1);
        for (int k = 0; k < nbytes * 100; k++) begin
            int bi = (k / 10) % 10;
            int j  = k / 100;
            if (k % 10 == 0) begin
                bitv = txd_of(sel);
                if (bi == 0 && bitv !== 1'b0) ferr++;
                if (bi == 9 && bitv !== 1'b1) ferr++;
                if (bi >= 1 && bi <= 8) rx_bytes[j][bi-1] = bitv;
            end else if (txd_of(sel) !== bitv) begin
                glitch++;
            end
            if (busy_of(sel) !== 1'b1) busy_drop++;
            if (done_of(sel) !== 1'b0) done_early++;
            if (sel == 0) begin
                if (rd_addr0 < prev_addr) nonmono++;
                if (rd_addr0 > 16'd3) oob++;
                else seen[rd_addr0[1:0]] = 1'b1;
                if (rd_addr0 > max_addr) max_addr = rd_addr0;
                prev_addr = rd_addr0;
                start0 = (k == restart_k);
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        check_eq({tag, "_done_at_end"}, 32'(done_of(sel)), 32'd1);
        check_eq({tag, "_busy_low_at_end"}, 32'(busy_of(sel)), 32'd0);
        @(negedge clk);
        check_eq({tag, "_done_single"}, 32'(done_of(sel)), 32'd0);
        for (int j = 0; j < nbytes; j++) begin
            check_eq($sformatf("%s_byte%0d", tag, j), 32'(rx_bytes[j]),
                     32'((sel == 0) ? exp0[j] : exp1[j]));
        end
        check_eq({tag, "_bit_glitches"}, 32'(glitch), 32'd0);
        check_eq({tag, "_framing_errs"}, 32'(ferr), 32'd0);
        check_eq({tag, "_busy_drops"}, 32'(busy_drop), 32'd0);
        check_eq({tag, "_done_early"}, 32'(done_early), 32'd0);
        if (sel == 0) begin
            check_eq({tag, "_addr_nonmono"}, 32'(nonmono), 32'd0);
            check_eq({tag, "_addr_oob"}, 32'(oob), 32'd0);
            check_eq({tag, "_addr_max"}, 32'(max_addr), 32'd3);
            check_eq({tag, "_addr_seen"}, 32'(seen), 32'hF);
        end
    endtask

    initial begin
        int viol_txd, viol_busy, viol_addr, viol_done, w;

        mem0[0] = 8'h01; mem0[1] = 8'h02; mem0[2] = 8'h80; mem0[3] = 8'hFF;
        exp0[0] = 8'hA5; exp0[1] = 8'h5A; exp0[2] = 8'h01; exp0[3] = 8'h02;
        exp0[4] = 8'h80; exp0[5] = 8'hFF; exp0[6] = 8'h82;
        exp1[0] = 8'hA5; exp1[1] = 8'h5A; exp1[2] = 8'hFF; exp1[3] = 8'hFF;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check_eq("rst_txd", 32'(txd0), 32'd1);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_done", 32'(done0), 32'd0);
        check_eq("rst_addr", 32'(rd_addr0), 32'd0);
        rst = 1'b0;

        // Idle for 1000 cycles with no start.
        viol_txd = 0; viol_busy = 0; viol_addr = 0; viol_done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || txd1 !== 1'b1) viol_txd++;
            if (busy0 !== 1'b0 || busy1 !== 1'b0) viol_busy++;
            if (rd_addr0 !== 16'd0 || rd_addr1 !== 16'd0) viol_addr++;
            if (done0 !== 1'b0 || done1 !== 1'b0) viol_done++;
        end
        check_eq("idle_txd_high", 32'(viol_txd), 32'd0);
        check_eq("idle_busy_low", 32'(viol_busy), 32'd0);
        check_eq("idle_addr_zero", 32'(viol_addr), 32'd0);
        check_eq("idle_no_done", 32'(viol_done), 32'd0);

        // Full frame.
        pulse_start(0, "full");
        recv_packet(0, 7, -1, "full");

        // Second start during byte 3 must be ignored.
        repeat (5) @(negedge clk);
        pulse_start(0, "restart");
        recv_packet(0, 7, 300, "restart");
        viol_txd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || busy0 !== 1'b0) viol_txd++;
        end
        check_eq("restart_no_second_frame", 32'(viol_txd), 32'd0);

        // Reset during payload byte 1 (0x02, bit d4 is low at cycle 350).
        pulse_start(0, "midrst");
        w = 0;
        while (txd0 !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (350) @(negedge clk);
        check_eq("midrst_txd_low_before", 32'(txd0), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("midrst_txd_high_now", 32'(txd0), 32'd1);
        check_eq("midrst_busy_low_now", 32'(busy0), 32'd0);
        viol_done = 0; viol_txd = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            if (done0 !== 1'b0) viol_done++;
            if (txd0 !== 1'b1) viol_txd++;
        end
        check_eq("midrst_no_done", 32'(viol_done), 32'd0);
        check_eq("midrst_line_idle", 32'(viol_txd), 32'd0);
        pulse_start(0, "after_rst");
        recv_packet(0, 7, -1, "after_rst");

        // Single-pixel configuration.
        pulse_start(1, "edge1");
        recv_packet(1, 4, -1, "edge1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
